memory_arbiter: RTL
===================

# memory_arbiter

Single-port RAM arbiter between the instruction-fetch path (iREN) and the data-memory path (dREN/dWEN) of the pipelined CPU. It sits between the datapath's request signals and the RAM, grants one requester at a time and holds the grant until the RAM reports ACCESS. It returns ihit/dhit plus the loaded word to the winner. Data requests win by default so the MEM stage is never starved by fetch.

## Interface
Parameters:
- FAIR_LIMIT, 4: consecutive data grants allowed while iREN is pending before fetch is forced (used only with MEM_ARB_FAIR_EN).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- iREN  in  1  instruction read request, held until ihit.
- iaddr  in  32  fetch address (word_t).
- dREN, dWEN  in  1 each  data read/write request, held until dhit.
- daddr, dstore  in  32 each  data address and write data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
- ramload  in  32  RAM read data.
- ramREN, ramWEN  out  1 each  RAM strobes.
- ramaddr, ramstore  out  32 each  RAM address and write data.
- ihit, dhit  out  1 each  one-cycle completion pulses.
- iload, dload  out  32 each  read data for each requester.

## Operation
- FSM states (arb_state_t): IDLE, SERVE_I, SERVE_D.
- IDLE: drive all RAM strobes to 0. Arbitrate registered at the next edge:
  - dREN|dWEN goes to SERVE_D.
  - Otherwise iREN goes to SERVE_I.
  - Otherwise stay in IDLE.
- SERVE_D:
  - ramaddr=daddr.
  - ramWEN=dWEN.
  - ramREN=dREN&~dWEN. dREN and dWEN together is treated as a write.
  - ramstore=dstore.
- SERVE_I: ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
- Completion: when ramstate==ACCESS in SERVE_x:
  - hit_x=1 (combinational).
  - load_x=ramload.
  - Next state is IDLE.
- BUSY/FREE: hold state and strobes.
- ERROR: hold state and retry. No hit is issued.
- Request withdrawn mid-service (iREN=0 in SERVE_I, or dREN=dWEN=0 in SERVE_D, e.g. flush or halt):
  - Strobes drop the same cycle.
  - No hit is issued.
  - Next state is IDLE.
- iload/dload are 0 whenever the matching hit is 0.
- Non-granted requester sees hit=0. Its request is not lost and is arbitrated at the next IDLE.

## Timing
- Reset values: state=IDLE; all outputs 0; fairness counter 0.
- RST is asynchronous: asserting it mid-access aborts the access immediately. The RAM transaction is abandoned and the requester must re-request.
- Latency from request (seen in IDLE at cycle 0) to hit:
  - Minimum 2 cycles: grant at edge 1, ACCESS in cycle 1, hit in cycle 1.
  - Plus N for N BUSY cycles.
- One mandatory IDLE cycle between consecutive transactions (bubble).
- Grant never changes while a transaction is in SERVE_x.

## Configuration
- MEM_ARB_FAIR_EN defined:
  - A counter (width clog2(FAIR_LIMIT+1)) increments on each SERVE_D grant made while iREN=1.
  - When the count equals FAIR_LIMIT and both paths request in IDLE, SERVE_I is granted and the counter clears.
  - Any SERVE_I grant, or iREN=0 in IDLE, also clears the counter.
- MEM_ARB_FAIR_EN undefined: strict data priority, and no counter logic is generated.

## Structure
- arb_state_t goes in cpu_types_pkg beside ramstate_t; word_t is reused.
- FAIR_LIMIT default is a package constant.
- The block connects through a memory_arbiter_if interface with modports arb and tb.
- The fairness counter goes in a sub-module, mem_arb_fair_ctr, instantiated only under MEM_ARB_FAIR_EN.

## Test plan
- Reset check: assert RST with iREN=1 -> all outputs 0, state IDLE. Release RST -> ihit arrives in cycle 1 when the RAM returns ACCESS.
- Simultaneous requests: iREN=1, dREN=1, daddr=0x40, ramload=0xDEADBEEF -> dhit with dload=0xDEADBEEF first. ihit follows at the earliest 2 cycles later.
- Busy write: dWEN=1, daddr=0x80, dstore=0x1234 with ramstate=BUSY for 3 cycles -> ramWEN and ramaddr held steady. dhit arrives in cycle 4 after grant.
- Withdrawal and reset mid-access:
  - iREN dropped in cycle 2 of SERVE_I -> ramREN=0 that cycle, no ihit, IDLE next.
  - RST asserted mid-SERVE_D -> outputs 0 asynchronously.
- Fairness, MEM_ARB_FAIR_EN with FAIR_LIMIT=4: iREN held, dREN re-asserted each IDLE -> exactly 4 dhits, then an ihit. Without the macro, ihit never occurs.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word, RAM handshake state and arbiter FSM state.
package cpu_types_pkg;

    localparam int unsigned WORD_W             = 32;
    localparam int unsigned FAIR_LIMIT_DEFAULT = 4;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Request/RAM bundle between the CPU datapath, the RAM and the memory arbiter.
interface memory_arbiter_if;
    import cpu_types_pkg::*;

    logic      iREN;
    word_t     iaddr;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    ramstate_t ramstate;
    word_t     ramload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    logic      ihit;
    logic      dhit;
    word_t     iload;
    word_t     dload;

    modport arb (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
        output ramREN, ramWEN, ramaddr, ramstore, ihit, dhit, iload, dload
    );

    modport tb (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
        input  ramREN, ramWEN, ramaddr, ramstore, ihit, dhit, iload, dload
    );

endinterface

// File: rtl/mem_arb_fair_ctr.sv
// Counts data grants made while fetch waits; flags when fetch must be forced.
module mem_arb_fair_ctr
    import cpu_types_pkg::*;
#(
    parameter int unsigned LIMIT = FAIR_LIMIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit_c
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count;

    // Consecutive starved-fetch data grant count, saturating at LIMIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_limit_c) begin
            count <= count + CNT_W'(1);
        end
    end

    assign at_limit_c = (count == CNT_W'(LIMIT));

endmodule

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter: data path wins by default, fetch served otherwise.
// Grant is held until the RAM reports ACCESS; hits and load data are
// combinational so the winner sees them in the completing cycle.
// Optional fairness: define MEM_ARB_FAIR_EN to force a fetch grant after
// FAIR_LIMIT consecutive data grants made while fetch was pending.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned FAIR_LIMIT = FAIR_LIMIT_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST,
    memory_arbiter_if.arb    bus
);

    // A zero limit would let fetch always beat data.
    if (FAIR_LIMIT == 0) begin : g_fair_limit_check
        $error("memory_arbiter: FAIR_LIMIT must be at least 1");
    end

    arb_state_t state;
    arb_state_t next_state;
    logic       d_req_c;
    logic       fetch_forced_c;

    assign d_req_c = bus.dREN | bus.dWEN;

`ifdef MEM_ARB_FAIR_EN
    logic fair_inc_c;
    logic fair_clr_c;
    logic fair_at_limit_c;

    // Count data grants that leave fetch waiting; clear on fetch grant or no fetch demand.
    always_comb begin
        fair_inc_c = (state == IDLE) && (next_state == SERVE_D) && bus.iREN;
        fair_clr_c = (state == IDLE) && ((next_state == SERVE_I) || !bus.iREN);
    end

    mem_arb_fair_ctr #(
        .LIMIT      (FAIR_LIMIT)
    ) u_fair_ctr (
        .clk        (CLK),
        .rst        (RST),
        .inc        (fair_inc_c),
        .clr        (fair_clr_c),
        .at_limit_c (fair_at_limit_c)
    );

    assign fetch_forced_c = bus.iREN && fair_at_limit_c;
`else
    assign fetch_forced_c = 1'b0;
`endif

    // Arbiter state register; reset aborts any in-flight RAM access.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Grant selection, RAM strobes and completion handling.
    always_comb begin
        next_state   = state;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.ihit     = 1'b0;
        bus.dhit     = 1'b0;
        bus.iload    = '0;
        bus.dload    = '0;

        case (state)
            IDLE: begin
                if (d_req_c && !fetch_forced_c) begin
                    next_state = SERVE_D;
                end else if (bus.iREN) begin
                    next_state = SERVE_I;
                end
            end

            SERVE_D: begin
                if (!d_req_c) begin
                    // Flushed or halted: drop the access without a hit.
                    next_state = IDLE;
                end else begin
                    bus.ramaddr  = bus.daddr;
                    bus.ramWEN   = bus.dWEN;
                    bus.ramREN   = bus.dREN & ~bus.dWEN;
                    bus.ramstore = bus.dstore;
                    if (bus.ramstate == ACCESS) begin
                        bus.dhit   = 1'b1;
                        bus.dload  = bus.ramload;
                        next_state = IDLE;
                    end
                end
            end

            SERVE_I: begin
                if (!bus.iREN) begin
                    next_state = IDLE;
                end else begin
                    bus.ramaddr = bus.iaddr;
                    bus.ramREN  = 1'b1;
                    if (bus.ramstate == ACCESS) begin
                        bus.ihit   = 1'b1;
                        bus.iload  = bus.ramload;
                        next_state = IDLE;
                    end
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule
